// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the binary-to-ASCII converter.
package bcd_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // IDLE: waiting for input, SHIFT: double-dabble iterations,
  // FMT: ASCII formatting, HOLD: result presented until consumed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FMT   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // One BCD nibble (0..9) to its ASCII character.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return ASCII_ZERO + {4'h0, nib};
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2ascii_seq.sv
// Iterative binary-to-decimal-ASCII converter (shift-add-3).
// Build option: BIN2ASCII_LZB_EN enables leading-zero blanking of the
// upper digits (leading '0' characters become spaces, digit 0 never blanked).
//
// Handshake: a transfer on either side happens on a rising CLK edge where
// valid and ready are both high. in_ready is a pure decode of IDLE;
// out_valid stays high in HOLD until out_ready is seen, and Data_out/ovf do
// not change while out_valid is high.
module bin2ascii_seq
  import bcd_pkg::*;
#(
  parameter int DATA_W = 30,
  parameter int DIGITS = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     Data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*DIGITS-1:0]   Data_out,
  output logic                  ovf,
  output state_t                o_dbg_state
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Value shown on Data_out before the first conversion completes.
  function automatic logic [8*DIGITS-1:0] reset_ascii();
    logic [8*DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef BIN2ASCII_LZB_EN
      v[8*i +: 8] = (i == 0) ? ASCII_ZERO : ASCII_SPACE;
`else
      v[8*i +: 8] = ASCII_ZERO;
`endif
    end
    return v;
  endfunction

  localparam logic [8*DIGITS-1:0] RST_ASCII = reset_ascii();

  state_t               r_state;
  state_t               w_next;
  logic [DATA_W-1:0]    r_sr;
  logic [4*DIGITS-1:0]  r_bcd;
  logic [4*DIGITS-1:0]  w_adj;
  logic                 r_ovf_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_out_valid;
  logic [8*DIGITS-1:0]  r_data_out;
  logic                 r_ovf;
  logic [8*DIGITS-1:0]  w_fmt;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign Data_out    = r_data_out;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

  // Per-digit add-3 correction, applied before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; HOLD always has out_valid high, so out_ready alone
  // completes the output handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_LAST) w_next = FMT;
      FMT:     w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Nibble to ASCII, with optional blanking of leading zero digits.
  always_comb begin
    logic l_seen;
    l_seen = 1'b0;
    w_fmt  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      l_seen = l_seen | (r_bcd[4*i +: 4] != 4'd0);
`ifdef BIN2ASCII_LZB_EN
      if (i != 0 && !l_seen) w_fmt[8*i +: 8] = ASCII_SPACE;
      else                   w_fmt[8*i +: 8] = nib2ascii(r_bcd[4*i +: 4]);
`else
      w_fmt[8*i +: 8] = nib2ascii(r_bcd[4*i +: 4]);
`endif
    end
  end

  // Conversion datapath and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sr        <= '0;
      r_bcd       <= '0;
      r_ovf_acc   <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= RST_ASCII;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sr      <= Data_in;
            r_bcd     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
          end
        end
        SHIFT: begin
          // A set MSB in the corrected top nibble means the doubled value
          // no longer fits in DIGITS decimal digits.
          r_bcd     <= {w_adj[4*DIGITS-2:0], r_sr[DATA_W-1]};
          r_ovf_acc <= r_ovf_acc | w_adj[4*DIGITS-1];
          r_sr      <= r_sr << 1;
          r_cnt     <= r_cnt + CNT_W'(1);
        end
        FMT: begin
          r_data_out  <= w_fmt;
          r_ovf       <= r_ovf_acc;
          r_out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2ascii_seq.sv
// Testbench for bin2ascii_seq: default instance (30 bits, 10 digits) driven
// through a scoreboard, plus a 9-digit instance for the overflow boundary.
module tb_bin2ascii_seq;
  import bcd_pkg::*;

  localparam int DATA_W = 30;
  localparam int DIGITS = 10;
  localparam int OW     = 8*DIGITS + 1;
  localparam int LAT    = DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_W-1:0]    Data_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [8*DIGITS-1:0]  Data_out;
  logic                 ovf;
  state_t               dbg_state;

  logic                 in_valid_9 = 1'b0;
  logic                 in_ready_9;
  logic [DATA_W-1:0]    data_in_9 = '0;
  logic                 out_valid_9;
  logic                 out_ready_9 = 1'b0;
  logic [71:0]          data_out_9;
  logic                 ovf_9;
  state_t               dbg_state_9;

  bin2ascii_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .Data_in(Data_in), .out_valid(out_valid), .out_ready(out_ready),
    .Data_out(Data_out), .ovf(ovf), .o_dbg_state(dbg_state)
  );

  bin2ascii_seq #(.DATA_W(DATA_W), .DIGITS(9)) dut9 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid_9), .in_ready(in_ready_9),
    .Data_in(data_in_9), .out_valid(out_valid_9), .out_ready(out_ready_9),
    .Data_out(data_out_9), .ovf(ovf_9), .o_dbg_state(dbg_state_9)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Leading '0' characters above digit 0 become spaces when blanking is built in.
  function automatic logic [79:0] blank(input logic [79:0] s, input int nd);
    logic [79:0] r;
    logic lead;
    r = s;
    lead = 1'b1;
`ifdef BIN2ASCII_LZB_EN
    for (int i = nd - 1; i >= 1; i--) begin
      if (lead && r[8*i +: 8] == 8'h30) r[8*i +: 8] = 8'h20;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  // Independent decimal model: repeated divide/modulo by ten.
  function automatic logic [OW-1:0] model(input longint unsigned v);
    logic [79:0] d;
    longint unsigned x;
    x = v;
    d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d[8*i +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    return {x != 0, blank(d, DIGITS)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    logic [OW-1:0] e;
    if (RST_N && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got output %0h with empty queue", Data_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", Data_out, e[79:0]);
        check("sb_ovf", ovf, e[80]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [DATA_W-1:0] din, input logic [OW-1:0] e);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge CLK); #1; t++; end
    if (t >= 200) timeout_fail("drive_in_ready");
    in_valid = 1'b1;
    Data_in  = din;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge: measures latency, optionally stalls the
  // consumer for 'hold' cycles, then completes the output handshake.
  task automatic take(input int hold, input int exp_lat, input string name);
    int lat;
    logic [79:0] snap;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge CLK); #1; lat++; end
    if (lat >= 200) timeout_fail({name, "_out_valid"});
    if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
    snap = Data_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      check({name, "_hold_data"}, Data_out, snap);
      check({name, "_hold_valid"}, out_valid, 1'b1);
      check({name, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check({name, "_valid_cleared"}, out_valid, 1'b0);
    check({name, "_in_ready_after"}, in_ready, 1'b1);
  endtask

  task automatic run9(input logic [DATA_W-1:0] din, input logic [71:0] txt, input logic exp_ovf);
    int t;
    logic [79:0] e;
    e = blank({8'h00, txt}, 9);
    t = 0;
    while (!in_ready_9 && t < 200) begin @(posedge CLK); #1; t++; end
    in_valid_9 = 1'b1;
    data_in_9  = din;
    @(posedge CLK); #1;
    in_valid_9 = 1'b0;
    t = 0;
    while (!out_valid_9 && t < 200) begin @(posedge CLK); #1; t++; end
    if (t >= 200) timeout_fail("d9_out_valid");
    check("d9_data", data_out_9, e[71:0]);
    check("d9_ovf", ovf_9, exp_ovf);
    out_ready_9 = 1'b1;
    @(posedge CLK); #1;
    out_ready_9 = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DATA_W-1:0] din;
    logic [79:0]       txt;
    logic              ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] zeros;
    int          seen;
    logic [DATA_W-1:0] r;

    vecs[0] = '{30'd0,          "0000000000", 1'b0};
    vecs[1] = '{30'd1073741823, "1073741823", 1'b0};
    vecs[2] = '{30'd4096,       "0000004096", 1'b0};
    vecs[3] = '{30'd12345,      "0000012345", 1'b0};
    vecs[4] = '{30'd999999999,  "0999999999", 1'b0};
    vecs[5] = '{30'd1,          "0000000001", 1'b0};
    vecs[6] = '{30'd10,         "0000000010", 1'b0};
    vecs[7] = '{30'd536870912,  "0536870912", 1'b0};
    zeros   = "0000000000";

    // Reset values while RST_N is held low.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_data", Data_out, blank(zeros, DIGITS));
    check("rst_state", dbg_state, IDLE);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Table: value, expected text, latency and a random consumer stall.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].din, {vecs[i].ovf, blank(vecs[i].txt, DIGITS)});
      if (i == 0) check("accept_state", dbg_state, SHIFT);
      take($urandom_range(0, 3), LAT, "vec");
    end

    // Consumer stalls 5 cycles with a new request already waiting.
    drive(30'd777, model(777));
    take(0, -1, "pre");  // warm-up conversion before the stall scenario
    drive(30'd777, model(777));
    in_valid = 1'b1;
    Data_in  = 30'd123456;
    exp_q.push_back(model(123456));
    take(5, LAT, "stall");
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("stall_next_accepted", dbg_state, SHIFT);
    take(0, LAT, "stall_next");

    // Reset in the middle of SHIFT discards the conversion.
    drive(30'd99999, model(99999));
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #3 RST_N = 1'b1;
    exp_q.delete();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_data", Data_out, blank(zeros, DIGITS));
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (out_valid) seen++;
    end
    check("mid_rst_no_spurious", seen, 0);
    drive(30'd12345, model(12345));
    take(0, LAT, "post_rst");

    // Nine-digit boundary.
    run9(30'd999999999, "999999999", 1'b0);
    run9(30'd1000000000, "000000000", 1'b1);
    run9(30'd123456789, "123456789", 1'b0);

    // Random values against the divide/modulo model.
    for (int i = 0; i < 6; i++) begin
      r = DATA_W'($urandom_range(0, 32'h3FFF_FFFF));
      drive(r, model(r));
      take($urandom_range(0, 2), LAT, "rand");
    end

    repeat (3) @(posedge CLK);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
